// File: rtl/agc_mon_pkg.sv
// Shared encodings for the AGC monitor-port sequencer: command ops, FSM
// states and the monitor bus width.
package agc_mon_pkg;

  localparam int MON_W = 16;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_START   = 3'd1,
    OP_STOP    = 3'd2,
    OP_RD_ERAS = 3'd3,
    OP_LD_ERAS = 3'd4,
    OP_RD_CHAN = 3'd5,
    OP_LD_CHAN = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_STRT = 3'd1;
  localparam logic [2:0] S_SYNC = 3'd2;
  localparam logic [2:0] S_ADDR = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  // Read ops return the MWL word captured in the data cycle.
  function automatic logic is_read(op_e op);
    return (op == OP_RD_ERAS) || (op == OP_RD_CHAN);
  endfunction

endpackage

// File: rtl/agc_monitor_sequencer_if.sv
// Host command/response bus of the monitor sequencer.
// Handshake: a command transfers on a SIM_CLK edge where cmd_valid & cmd_ready;
// cmd_ready is high only while the sequencer is idle, and cmd_op/addr/data must
// be stable while cmd_valid is high. rsp_valid pulses once per accepted command
// and rsp_data/rsp_err stay valid until the next rsp_valid (no backpressure).
interface agc_monitor_sequencer_if;
  import agc_mon_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [MON_W-1:0] cmd_addr;
  logic [MON_W-1:0] cmd_data;
  logic             rsp_valid;
  logic [MON_W-1:0] rsp_data;
  logic             rsp_err;
  logic             busy;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );

endinterface

// File: rtl/agc_mon_sync_edge.sv
// Two-flop synchroniser for an AGC-domain signal; q is either the synchronised
// level (EDGE = 0) or a one-cycle rising-edge pulse (EDGE = 1).
module agc_mon_sync_edge #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1, s2, s3;

  // Metastability stages plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q = EDGE ? (s2 & ~s3) : s2;

endmodule

// File: rtl/agc_monitor_sequencer.sv
// Host-side AGC monitor port sequencer: one command at a time, timed against
// the synchronised MT01/MT10/MT12 pulses, with timeout and GOJAM abort.
module agc_monitor_sequencer
  import agc_mon_pkg::*;
#(
  parameter int STRT_CYC    = 250,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST_n,
  agc_monitor_sequencer_if.slave bus,
  input  logic             MT01,
  input  logic             MT10,
  input  logic             MT12,
  input  logic             MGOJAM,
  input  logic [MON_W-1:0] MWL,
  output logic [MON_W-1:0] MDT,
  output logic             MSTRT,
  output logic             MSTP,
  output logic             MREAD,
  output logic             MLOAD,
  output logic             MRDCH,
  output logic             MLDCH,
  output logic [2:0]       dbg_state
);

  localparam int STRT_W = $clog2(STRT_CYC + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

  logic mt01_rise, mt10_rise, mt12_rise, gojam;

  agc_mon_sync_edge #(.EDGE(1'b1)) u_mt01 (.clk(SIM_CLK), .rst_n(SIM_RST_n), .d(MT01),   .q(mt01_rise));
  agc_mon_sync_edge #(.EDGE(1'b1)) u_mt10 (.clk(SIM_CLK), .rst_n(SIM_RST_n), .d(MT10),   .q(mt10_rise));
  agc_mon_sync_edge #(.EDGE(1'b1)) u_mt12 (.clk(SIM_CLK), .rst_n(SIM_RST_n), .d(MT12),   .q(mt12_rise));
  agc_mon_sync_edge #(.EDGE(1'b0)) u_jam  (.clk(SIM_CLK), .rst_n(SIM_RST_n), .d(MGOJAM), .q(gojam));

  logic [2:0]       state_q, state_d;
  op_e              op_q;
  logic [MON_W-1:0] addr_q, data_q, cap_q, cap_d;
  logic [MON_W-1:0] rsp_data_q, data_d;
  logic             rsp_err_q, err_d;
  logic             mstp_q;
  logic [STRT_W-1:0] strt_q;
  logic [TMO_W-1:0]  tmo_q;
  logic accept, awaited, waiting, abort, go_resp;

  assign accept = bus.cmd_valid && (state_q == S_IDLE);

  // Next-state, abort detection and the response word latched on RESP entry.
  always_comb begin
    state_d = state_q;
    awaited = 1'b0;
    go_resp = 1'b0;
    err_d   = 1'b0;
    data_d  = '0;
    cap_d   = (state_q == S_DATA && mt10_rise) ? MWL : cap_q;
    waiting = (state_q == S_SYNC) || (state_q == S_ADDR) || (state_q == S_DATA);
    case (state_q)
      S_SYNC:  awaited = mt01_rise;
      S_ADDR:  awaited = mt12_rise;
      S_DATA:  awaited = mt10_rise | mt12_rise;
      default: awaited = 1'b0;
    endcase
    abort = waiting && (gojam || ((tmo_q == '0) && !awaited));
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_NOP, OP_STOP: begin state_d = S_RESP; go_resp = 1'b1; end
            OP_START:        state_d = S_STRT;
            OP_RD_ERAS, OP_LD_ERAS, OP_RD_CHAN, OP_LD_CHAN: state_d = S_SYNC;
            default: begin state_d = S_RESP; go_resp = 1'b1; err_d = 1'b1; end
          endcase
        end
      end
      S_STRT: if (strt_q == '0) begin state_d = S_RESP; go_resp = 1'b1; end
      S_SYNC: if (mt01_rise) state_d = S_ADDR;
      S_ADDR: if (mt12_rise) state_d = S_DATA;
      S_DATA: begin
        // A coincident MT10 edge is already folded into cap_d.
        if (mt12_rise) begin
          state_d = S_RESP;
          go_resp = 1'b1;
          data_d  = is_read(op_q) ? cap_d : '0;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_RESP;
      go_resp = 1'b1;
      err_d   = 1'b1;
      data_d  = '0;
    end
  end

  // State, command latches, counters, MSTP level and response registers.
  always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
    if (!SIM_RST_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      addr_q     <= '0;
      data_q     <= '0;
      cap_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      mstp_q     <= 1'b0;
      strt_q     <= '0;
      tmo_q      <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= accept ? '0 : cap_d;
      if (accept) begin
        op_q   <= op_e'(bus.cmd_op);
        addr_q <= bus.cmd_addr;
        data_q <= bus.cmd_data;
      end
      if (accept || awaited) tmo_q <= TMO_W'(TIMEOUT_CYC - 1);
      else if (tmo_q != '0)  tmo_q <= tmo_q - TMO_W'(1);
      if (accept && bus.cmd_op == OP_START) begin
        mstp_q <= 1'b0;
        strt_q <= STRT_W'(STRT_CYC - 1);
      end else if (state_q == S_STRT && strt_q != '0) begin
        strt_q <= strt_q - STRT_W'(1);
      end
      if (accept && bus.cmd_op == OP_STOP) mstp_q <= 1'b1;
      if (go_resp) begin
        rsp_err_q  <= err_d;
        rsp_data_q <= data_d;
      end
    end
  end

  logic xfer;
  assign xfer  = (state_q == S_ADDR) || (state_q == S_DATA);
  assign MREAD = xfer && (op_q == OP_RD_ERAS);
  assign MLOAD = xfer && (op_q == OP_LD_ERAS);
  assign MRDCH = xfer && (op_q == OP_RD_CHAN);
  assign MLDCH = xfer && (op_q == OP_LD_CHAN);
  assign MDT   = (state_q == S_ADDR) ? addr_q :
                 (state_q == S_DATA && !is_read(op_q)) ? data_q : '0;
  assign MSTRT = (state_q == S_STRT);
  assign MSTP  = mstp_q;

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dbg_state     = state_q;

endmodule
